// File: rtl/enc_rr_arbiter_pkg.sv
// enc_arb_pkg: shared constants, FSM state type and rotating-priority pick for enc_rr_arbiter
package enc_arb_pkg;
  localparam int N = 16;
  localparam int IDXW = 4;
  localparam int HCW = 8;
  localparam int DW = 2 * N;
  typedef enum logic {IDLE, GRANT} state_t;
  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] r, input logic [IDXW-1:0] p);
    logic [DW-1:0] d, f;
    d = {r, r} & ~((DW'(1) << p) - DW'(1));
    f = d & (~d + DW'(1));
    return f[N-1:0] | f[DW-1:N];
  endfunction
endpackage

// File: rtl/enc_rr_arbiter_encoder.sv
// enc_rr_arbiter_encoder: 16->4 one-hot to binary encoder (onehot in, idx out)
module enc_rr_arbiter_encoder
  import enc_arb_pkg::*;
(
  input  logic [N-1:0]    onehot,
  input  logic            unused_tie,
  output logic [IDXW-1:0] idx
);
  logic tie_sink;
  assign tie_sink = unused_tie;
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) idx = idx | (onehot[i] ? IDXW'(i) : '0);
  end
endmodule

// File: rtl/enc_rr_arbiter.sv
// enc_rr_arbiter: 16-way round-robin arbiter (req/done in; gnt, gnt_idx, gnt_valid, timeout out)
module enc_rr_arbiter
  import enc_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            done,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_valid,
  output logic            timeout
);
  state_t state, state_n;
  logic [IDXW-1:0] ptr, ptr_n, idx_n, enc_idx;
  logic [HCW-1:0] hold_cnt, hold_n;
  logic [N-1:0] pick, gnt_n;
  logic lim, rel, arb, win, to_n;
  enc_rr_arbiter_encoder u_enc (.onehot(pick), .unused_tie(1'b0), .idx(enc_idx));
  always_comb begin
    lim = hold_cnt == HCW'(MAX_HOLD - 1);
    rel = (state == GRANT) && (done || !req[gnt_idx] || lim);
    arb = (state == IDLE) || rel;
    pick = rr_pick(req, ptr);
    win = arb && (|pick);
    state_n = win ? GRANT : (arb ? IDLE : state);
    gnt_n = win ? pick : (arb ? '0 : gnt);
    idx_n = win ? enc_idx : gnt_idx;
    ptr_n = win ? enc_idx + IDXW'(1) : ptr;
    hold_n = arb ? '0 : hold_cnt + HCW'(1);
    to_n = rel && !done && req[gnt_idx];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      hold_cnt <= '0;
      gnt <= '0;
      gnt_idx <= '0;
      timeout <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      hold_cnt <= hold_n;
      gnt <= gnt_n;
      gnt_idx <= idx_n;
      timeout <= to_n;
    end
  end
  assign gnt_valid = state == GRANT;
endmodule
